// File: rtl/step_protocol_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : step_protocol_generator                                        |
// | Purpose  : Two-level (low/high) protocol generator with linear ramps     |
// |            between the levels and a matching indicator trace. Runs a     |
// |            programmable number of cycles (0 = forever), then holds L     |
// |            and flags completion.                                         |
// | Ports    : clk_i, rst_i (sync, active-high), enable_i (run request)      |
// |            low_level_i/high_level_i : signed levels L and H              |
// |            dwell_low_i/dwell_high_i : clocks at L / H (0 treated as 1)   |
// |            ramp_step_i              : unsigned step per clock, 0 = jump  |
// |            n_cycles_i               : cycles to run, 0 = infinite        |
// |            data_o, indicator_o, cycle_count_o, cycle_pulse_o,            |
// |            busy_o, done_o           : all registered                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module step_protocol_generator #(
  parameter int                 WIDTH     = 14,
  parameter int                 CNT_WIDTH = 32,
  parameter logic [WIDTH-1:0]   IND_VALUE = 'h1FFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [WIDTH-1:0]     low_level_i,
  input  logic [WIDTH-1:0]     high_level_i,
  input  logic [CNT_WIDTH-1:0] dwell_low_i,
  input  logic [CNT_WIDTH-1:0] dwell_high_i,
  input  logic [WIDTH-1:0]     ramp_step_i,
  input  logic [CNT_WIDTH-1:0] n_cycles_i,
  output logic [WIDTH-1:0]     data_o,
  output logic [WIDTH-1:0]     indicator_o,
  output logic [CNT_WIDTH-1:0] cycle_count_o,
  output logic                 cycle_pulse_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOW       = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_HIGH      = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t               r_state, w_state_n;

  // Configuration captured on IDLE exit
  logic [WIDTH-1:0]     r_low, r_high, r_step;
  logic [CNT_WIDTH-1:0] r_dwell_low, r_dwell_high, r_n_cycles;

  // Remaining clocks in the current dwell after the present one
  logic [CNT_WIDTH-1:0] r_dwell, w_dwell_n;

  logic [WIDTH-1:0]     r_data, w_data_n;
  logic [WIDTH-1:0]     r_ind, w_ind_n;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_n;
  logic                 r_pulse, w_pulse_n;
  logic                 r_busy, w_busy_n;
  logic                 r_done, w_done_n;

  logic                 w_load;
  logic [WIDTH-1:0]     w_target;
  logic signed [WIDTH:0] w_diff;
  logic [WIDTH:0]       w_dist;
  logic                 w_land;
  logic [WIDTH-1:0]     w_stepped;
  logic [WIDTH-1:0]     w_step_val;

  // A dwell of N clocks loads N-1 so the counter hits zero on the last clock
  function automatic logic [CNT_WIDTH-1:0] dwell_reload(input logic [CNT_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  assign w_load = (r_state == S_IDLE) && enable_i;

  // Step rule: rising phases head for H, falling phases head for L
  assign w_target = ((r_state == S_LOW) || (r_state == S_RAMP_UP)) ? r_high : r_low;

  // One extra bit keeps T-v exact for any pair of signed WIDTH-bit values
  assign w_diff = $signed({w_target[WIDTH-1], w_target}) - $signed({r_data[WIDTH-1], r_data});
  assign w_dist = w_diff[WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_land = (r_step == '0) || (w_dist <= {1'b0, r_step});

  // Only used when not landing, so v+-S lies strictly between v and T and
  // the WIDTH-bit modular result is exact.
  assign w_stepped  = w_diff[WIDTH] ? (r_data - r_step) : (r_data + r_step);
  assign w_step_val = w_land ? w_target : w_stepped;

  always_comb begin
    w_state_n = r_state;
    w_data_n  = r_data;
    w_cnt_n   = r_cnt;
    w_pulse_n = 1'b0;
    w_dwell_n = r_dwell;

    case (r_state)
      S_IDLE: begin
        w_data_n = '0;
        if (enable_i) begin
          w_state_n = S_LOW;
          w_data_n  = low_level_i;
          w_cnt_n   = '0;
          w_dwell_n = dwell_reload(dwell_low_i);
        end
      end

      S_LOW, S_RAMP_UP: begin
        if (!enable_i) begin
          w_state_n = S_IDLE;
          w_data_n  = '0;
        end else if ((r_state == S_LOW) && (r_dwell != '0)) begin
          w_dwell_n = r_dwell - 1'b1;
        end else if (w_land) begin
          w_state_n = S_HIGH;
          w_data_n  = w_step_val;
          w_dwell_n = dwell_reload(r_dwell_high);
        end else begin
          w_state_n = S_RAMP_UP;
          w_data_n  = w_step_val;
        end
      end

      S_HIGH, S_RAMP_DOWN: begin
        if (!enable_i) begin
          w_state_n = S_IDLE;
          w_data_n  = '0;
        end else if ((r_state == S_HIGH) && (r_dwell != '0)) begin
          w_dwell_n = r_dwell - 1'b1;
        end else if (w_land) begin
          // Landing on L completes one cycle
          w_data_n  = r_low;
          w_cnt_n   = r_cnt + 1'b1;
          w_pulse_n = 1'b1;
          if ((r_n_cycles != '0) && (w_cnt_n == r_n_cycles)) begin
            w_state_n = S_DONE;
          end else begin
            w_state_n = S_LOW;
            w_dwell_n = dwell_reload(r_dwell_low);
          end
        end else begin
          w_state_n = S_RAMP_DOWN;
          w_data_n  = w_step_val;
        end
      end

      S_DONE: begin
        w_data_n = r_low;
        if (!enable_i) begin
          w_state_n = S_IDLE;
          w_data_n  = '0;
        end
      end

      default: begin
        w_state_n = S_IDLE;
        w_data_n  = '0;
      end
    endcase

    // Flags follow the next state so they align with data on the same edge
    w_ind_n  = (w_state_n == S_HIGH) ? IND_VALUE : '0;
    w_busy_n = (w_state_n != S_IDLE) && (w_state_n != S_DONE);
    w_done_n = (w_state_n == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_ind        <= '0;
      r_cnt        <= '0;
      r_pulse      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dwell      <= '0;
      r_low        <= '0;
      r_high       <= '0;
      r_step       <= '0;
      r_dwell_low  <= '0;
      r_dwell_high <= '0;
      r_n_cycles   <= '0;
    end else begin
      r_state <= w_state_n;
      r_data  <= w_data_n;
      r_ind   <= w_ind_n;
      r_cnt   <= w_cnt_n;
      r_pulse <= w_pulse_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_dwell <= w_dwell_n;
      if (w_load) begin
        r_low        <= low_level_i;
        r_high       <= high_level_i;
        r_step       <= ramp_step_i;
        r_dwell_low  <= dwell_low_i;
        r_dwell_high <= dwell_high_i;
        r_n_cycles   <= n_cycles_i;
      end
    end
  end

  assign data_o        = r_data;
  assign indicator_o   = r_ind;
  assign cycle_count_o = r_cnt;
  assign cycle_pulse_o = r_pulse;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_step_protocol_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_step_protocol_generator                                    |
// | Purpose  : Directed-vector scoreboard bench for step_protocol_generator. |
// |            Stimulus pushes the hand-computed expected output sample for  |
// |            each clock; a monitor pops and compares after every edge.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_step_protocol_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [13:0] low_level, high_level, ramp_step;
  logic [31:0] dwell_low, dwell_high, n_cycles;
  logic [13:0] data;
  logic [13:0] indicator;
  logic [31:0] cycle_count;
  logic        cycle_pulse, busy, done;

  int tests  = 0;
  int fails  = 0;
  int sample = 0;

  typedef struct {
    logic [13:0] data;
    logic [13:0] ind;
    logic [31:0] cnt;
    logic        pulse;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  step_protocol_generator dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .low_level_i   (low_level),
    .high_level_i  (high_level),
    .dwell_low_i   (dwell_low),
    .dwell_high_i  (dwell_high),
    .ramp_step_i   (ramp_step),
    .n_cycles_i    (n_cycles),
    .data_o        (data),
    .indicator_o   (indicator),
    .cycle_count_o (cycle_count),
    .cycle_pulse_o (cycle_pulse),
    .busy_o        (busy),
    .done_o        (done)
  );

  // Monitor: one expected sample per clock edge, checked 1 time unit later
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      tests++;
      if (data !== e.data || indicator !== e.ind || cycle_count !== e.cnt ||
          cycle_pulse !== e.pulse || busy !== e.busy || done !== e.done) begin
        fails++;
        $display("FAIL sample %0d: got data=%h ind=%h cnt=%0d pulse=%b busy=%b done=%b, expected data=%h ind=%h cnt=%0d pulse=%b busy=%b done=%b",
                 sample, data, indicator, cycle_count, cycle_pulse, busy, done,
                 e.data, e.ind, e.cnt, e.pulse, e.busy, e.done);
      end
      sample++;
    end
  end

  task automatic cfg(input int l, input int h, input int s,
                     input int dl, input int dh, input int n);
    low_level  = l[13:0];
    high_level = h[13:0];
    ramp_step  = s[13:0];
    dwell_low  = dl;
    dwell_high = dh;
    n_cycles   = n;
  endtask

  // Push the sample expected after the next rising edge, then advance a clock
  task automatic cyc(input int d, input bit ind, input int cnt,
                     input bit pulse, input bit bsy, input bit dn);
    exp_t x;
    x.data  = d[13:0];
    x.ind   = ind ? 14'h1FFF : 14'h0000;
    x.cnt   = cnt;
    x.pulse = pulse;
    x.busy  = bsy;
    x.done  = dn;
    q.push_back(x);
    @(negedge clk);
  endtask

  // L=-500 -> H=1000 -> L with S=300 and a 3-clock high dwell
  task automatic updown(input int c);
    int seq[11] = '{-200, 100, 400, 700, 1000, 1000, 1000, 700, 400, 100, -200};
    for (int i = 0; i < 11; i++)
      cyc(seq[i], (i >= 4 && i <= 6), c, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    cfg(-500, 1000, 300, 4, 3, 2);
    @(negedge clk);

    // Reset held with enable high
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic two-cycle run
    repeat (4) cyc(-500, 0, 0, 0, 1, 0);
    updown(0);
    cyc(-500, 0, 1, 1, 1, 0);
    repeat (3) cyc(-500, 0, 1, 0, 1, 0);
    updown(1);
    cyc(-500, 0, 2, 1, 0, 1);
    repeat (2) cyc(-500, 0, 2, 0, 0, 1);
    enable = 1'b0;
    cyc(0, 0, 2, 0, 0, 0);

    // Instant jump, zero dwells, infinite run
    cfg(10, 20, 0, 0, 0, 0);
    enable = 1'b1;
    cyc(10, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(20, 1, i - 1, 0, 1, 0);
      cyc(10, 0, i, 1, 1, 0);
    end
    enable = 1'b0;
    cyc(0, 0, 5, 0, 0, 0);

    // Inverted levels; inputs scrambled after start must be ignored
    cfg(800, -800, 1000, 1, 2, 1);
    enable = 1'b1;
    cyc(800, 0, 0, 0, 1, 0);
    cfg(0, 0, 0, 50, 50, 0);
    cyc(-200, 0, 0, 0, 1, 0);
    repeat (2) cyc(-800, 1, 0, 0, 1, 0);
    cyc(200, 0, 0, 0, 1, 0);
    cyc(800, 0, 1, 1, 0, 1);
    cyc(800, 0, 1, 0, 0, 1);
    enable = 1'b0;
    cyc(0, 0, 1, 0, 0, 0);

    // Abort in RAMP_UP
    cfg(0, 1000, 300, 0, 0, 0);
    enable = 1'b1;
    cyc(0, 0, 0, 0, 1, 0);
    cyc(300, 0, 0, 0, 1, 0);
    enable = 1'b0;
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    // Reset pulsed in HIGH after one completed cycle, then fresh restart
    cfg(5, 100, 0, 1, 1, 0);
    enable = 1'b1;
    cyc(5, 0, 0, 0, 1, 0);
    cyc(100, 1, 0, 0, 1, 0);
    cyc(5, 0, 1, 1, 1, 0);
    cyc(100, 1, 1, 0, 1, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(5, 0, 0, 0, 1, 0);
    cyc(100, 1, 0, 0, 1, 0);
    enable = 1'b0;

    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected samples left unchecked, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/step_protocol_generator.md
Name: step_protocol_generator

Overview:
- Generates one two-level (low/high) protocol with linear ramps between the levels, plus a matching indicator trace.
- Sits directly upstream of the protocol output multiplexer and drives one of its dataN/indicatorN input pairs.
- Runs a programmable number of cycles (or forever), then holds and flags completion.
- All outputs are registered; state and outputs update on the same clk_i edge.

Parameters:
- WIDTH, 14, sample width of data_o, indicator_o and the levels (signed two's complement, DAC format)
- CNT_WIDTH, 32, width of the dwell, cycle-count and n_cycles fields
- IND_VALUE, 14'h1FFF, indicator_o value while in HIGH

Ports:
- clk_i  in  1  system clock; one clock domain, all logic on posedge
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  run request; level-sensitive
- low_level_i  in  WIDTH  signed low level L
- high_level_i  in  WIDTH  signed high level H (H<L allowed)
- dwell_low_i  in  CNT_WIDTH  cycles spent at L
- dwell_high_i  in  CNT_WIDTH  cycles spent at H
- ramp_step_i  in  WIDTH  unsigned step S per clock during ramps; 0 = instant jump
- n_cycles_i  in  CNT_WIDTH  number of full cycles; 0 = infinite
- data_o  out  WIDTH  protocol sample
- indicator_o  out  WIDTH  IND_VALUE in HIGH, else 0
- cycle_count_o  out  CNT_WIDTH  completed cycles since start
- cycle_pulse_o  out  1  one-clock pulse on each cycle completion
- busy_o  out  1  high in every state except IDLE and DONE
- done_o  out  1  high in DONE

Behaviour:
- States: IDLE, LOW, RAMP_UP, HIGH, RAMP_DOWN, DONE.
- Reset (rst_i=1, synchronous, overrides everything): state=IDLE; data_o, indicator_o, cycle_count_o all 0; cycle_pulse_o, busy_o, done_o all 0.
- IDLE: data_o=0, indicator_o=0.
- IDLE -> LOW when enable_i=1 on the next edge.
  - On that same edge, L, H, S, both dwells and n_cycles are latched; inputs are not used again until the next IDLE exit.
  - cycle_count_o is cleared and data_o<=L.
- LOW and HIGH: data_o is held for exactly max(dwell,1) clocks (dwell 0 is treated as 1), counted by a dwell counter.
- Leaving LOW on its last clock, the step rule is applied toward H; leaving HIGH, it is applied toward L.
- Step rule, toward target T from current value v, with d=|T-v|:
  - If S=0 or d<=S: data_o<=T and enter the destination dwell state (HIGH or LOW).
  - Otherwise: data_o<=v±S and enter/stay in the RAMP state.
  - Arithmetic is done in WIDTH+1 bits; no overflow or wrap is possible because the value is clamped to T.
- Ramp length is ceil(d/S)-1 intermediate samples. Example: L=0, H=1000, S=300 gives 300, 600, 900, then 1000 in HIGH.
- Cycle completion is the edge where RAMP_DOWN or HIGH lands on L:
  - cycle_count_o increments.
  - cycle_pulse_o=1 for that one clock.
  - If n_cycles≠0 and the new count equals n_cycles: enter DONE. Otherwise enter LOW and start a new low dwell.
- DONE: data_o=L, indicator_o=0, done_o=1, busy_o=0. Stays in DONE until enable_i=0, then returns to IDLE next edge (data_o<=0).
- enable_i=0 in any busy state: next edge goes to IDLE, data_o<=0, indicator_o<=0. cycle_count_o keeps its value until the next start.
- indicator_o=IND_VALUE exactly for the clocks in which state=HIGH, and aligns sample-for-sample with data_o.
- Reset asserted mid-run: IDLE on the same edge, all outputs return to reset values. No restart until rst_i=0 and enable_i=1.

Test Plan:
- Reset/idle: rst_i=1 for 3 clocks with enable_i=1 -> all outputs 0 and state IDLE; first edge after rst_i=0 gives data_o=L.
- Basic cycle: L=-500, H=1000, S=300, dwell_low=4, dwell_high=3, n_cycles=2 ->
  - data_o = -500×4, -200, 100, 400, 700, 1000×3 (indicator 1FFF on those 3 clocks), then 700, 400, 100, -200.
  - Landing on -500 gives cycle_pulse_o=1 and cycle_count_o=1.
  - After the second cycle: DONE, done_o=1, data_o=-500.
- Instant jump with zero dwells: S=0, dwell_low=0, dwell_high=0, L=10, H=20, n_cycles=0 -> data_o alternates 10, 20 every clock indefinitely; cycle_count_o increments every 2 clocks.
- Inverted levels: L=800, H=-800, S=1000 -> data_o 800, then -200, then -800 in HIGH with indicator set; ramp down -800 -> 200 -> 800.
- Abort: deassert enable_i mid RAMP_UP -> next clock data_o=0, busy_o=0. Input changes made during the run have no effect until restart.
- Mid-run reset: rst_i pulsed in HIGH -> next clock all outputs 0; re-enable starts from a fresh low dwell with cycle_count_o=0.
